// File: rtl/mem_stage_sram.sv
// Memory stage: 32-bit loads/stores on a 16-bit async SRAM as two half-word accesses.
// Latency: non-memory ops pass through combinationally; memory ops occupy 2*LAT+2 cycles.
// Backpressure: ready is low from op detection through the HI half, high for one DONE cycle.
module mem_stage_sram #(
  parameter int BASE_ADDR = 1024,
  parameter int LAT       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [3:0]  dest_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rm_in,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic [3:0]  dest_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          store_q;
  logic [16:0]   word_q;
  logic [15:0]   data_hi_q;
  logic [31:0]   mem_data_q;
  logic [17:0]   sram_addr_q;
  logic [15:0]   sram_dq_q;
  logic          sram_oe_q;
  logic          sram_we_n_q;

  logic          mem_op_d;
  logic [16:0]   word_d;

  // Pipeline control fields are forwarded untouched toward WB
  assign wb_en_out    = wb_en_in;
  assign mem_read_out = mem_read_in;
  assign dest_out     = dest_in;
  assign alu_res_out  = alu_res_in;

  // Word index relative to the SRAM base; low addresses wrap modulo 2^17 words
  assign mem_op_d = mem_read_in | mem_write_in;
  assign word_d   = 17'((alu_res_in - 32'(BASE_ADDR)) >> 2);

  // Freeze upstream while an op is being detected or is on the bus
  always_comb begin
    ready = 1'b0;
    case (state_q)
      S_IDLE:  ready = ~mem_op_d;
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign mem_data_out = mem_data_q;
  assign sram_addr    = sram_addr_q;
  assign sram_dq_out  = sram_dq_q;
  assign sram_dq_oe   = sram_oe_q;
  assign sram_we_n    = sram_we_n_q;

  // Access sequencer: bus outputs are registered so they line up with LO/HI states
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      word_q      <= '0;
      data_hi_q   <= '0;
      mem_data_q  <= '0;
      sram_addr_q <= '0;
      sram_dq_q   <= '0;
      sram_oe_q   <= 1'b0;
      sram_we_n_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_op_d) begin
            state_q     <= S_LO;
            cnt_q       <= '0;
            store_q     <= mem_write_in;
            word_q      <= word_d;
            data_hi_q   <= val_rm_in[31:16];
            sram_addr_q <= {word_d, 1'b0};
            sram_dq_q   <= val_rm_in[15:0];
            sram_oe_q   <= mem_write_in;
            sram_we_n_q <= ~mem_write_in;
          end
        end
        S_LO: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_HI;
            cnt_q       <= '0;
            sram_addr_q <= {word_q, 1'b1};
            sram_dq_q   <= data_hi_q;
            if (!store_q) mem_data_q[15:0] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HI: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_DONE;
            cnt_q       <= '0;
            sram_oe_q   <= 1'b0;
            sram_we_n_q <= 1'b1;
            if (!store_q) mem_data_q[31:16] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
